srisc_core_mc: RTL and testbench
================================

Name: srisc_core_mc

Overview:
- Parametrised multi-cycle successor to the lab CPU: 8-register load/run machine with internal writable instruction memory.
- Adds a start/halted handshake, a generic data width and imem depth, and a branch instruction.
- Program is loaded through a write port, then run from `start_pc`.
- `out` shows the last OUT result.

Parameters:
- DATA_W, 16, register/ALU/out width (8..32); immediates sign-extend to DATA_W.
- ADDR_W, 8, pc and imem address width; imem depth = 2**ADDR_W words of 16 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level sampled in IDLE/HALTED; begins execution at start_pc.
- start_pc  in  ADDR_W  first instruction address.
- imem_we  in  1  imem write enable.
- imem_waddr  in  ADDR_W  write address.
- imem_wdata  in  16  instruction word.
- out  out  DATA_W  value of last OUT instruction.
- halted  out  1  high in HALTED state.
- busy  out  1  high in FETCH/DECODE/EXEC.

Behaviour:
- Reset
  - Clears R0..R7, pc, ir, out, halted and busy to 0; state <= IDLE.
  - imem contents are NOT cleared.
  - Reset mid-program aborts immediately; no partial writeback.
- States: IDLE, FETCH, DECODE, EXEC, HALTED.
  - IDLE / HALTED with start=1: pc <= start_pc, next FETCH, halted <= 0. With start=0: stay.
  - FETCH: ir <= imem[pc] (synchronous read); pc <= pc+1 mod 2**ADDR_W; next DECODE.
  - DECODE: A <= R[ir[9:7]], B <= R[ir[6:4]], D <= R[ir[12:10]]; next EXEC.
  - EXEC: perform op; next FETCH, or HALTED for HALT.
  - Every instruction takes exactly 3 cycles; start-to-first-FETCH is 1 cycle.
- Encoding: op=ir[15:13], Rd=ir[12:10], Rn=ir[9:7], Rm=ir[6:4], imm8=ir[7:0].
  - 000 MOVI: Rd <= sext(imm8).
  - 001 ADD: Rd <= A+B, modulo 2**DATA_W.
  - 010 SUB: Rd <= A-B, modulo 2**DATA_W.
  - 011 AND: Rd <= A&B.
  - 100 MVN: Rd <= ~B.
  - 101 OUT: out <= A.
  - 110 BNZ: if D != 0 then pc <= imm8 (zero-extended or truncated to ADDR_W); else fall through.
  - 111 HALT: no register change; enter HALTED.
- imem writes
  - Take effect only in IDLE or HALTED; ignored while busy.
  - A write and a start in the same cycle: the write lands first, so FETCH sees the new word.
- pc wrap: fetch from address 2**ADDR_W-1 continues at 0.
- `out` holds its value across HALTED and restart; only OUT or rst changes it.

Optional Feature:
- Macro: SRISC_RETIRE_CNT_EN.
- When defined:
  - Adds output port `retired` (32 bits).
  - Increments once per EXEC cycle, HALT included.
  - Cleared by rst and on each start acceptance; saturates at 2**32-1.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Sum loop
  - Stimulus: load at addr 4..11: MOVI R0,4; MOVI R1,0xFF; MOVI R2,0; ADD R2,R2,R0; ADD R0,R0,R1; BNZ R0,7; OUT R2; HALT. Pulse start with start_pc=4.
  - Required: halted=1 exactly 52 cycles after the start cycle; out=0x000A; retired=17 (if EN).
- Reset mid-run
  - Stimulus: assert rst during the loop above.
  - Required: next cycle out=0, busy=0, halted=0. Restart runs to out=0x000A again (imem kept).
- Width/wrap, DATA_W=8
  - Stimulus: MOVI R0,0x7F; MOVI R1,1; ADD R2,R0,R1; OUT R2; HALT.
  - Required: out=0x80. Then SUB of 0-1 gives out=0xFF.
- Sign extension, DATA_W=16
  - Stimulus: MOVI R3,0x80; OUT R3.
  - Required: out=0xFF80. MVN of R3 gives 0x007F.
- Write-while-busy and pc wrap
  - Stimulus: imem_we during EXEC.
  - Required: word unchanged on readback run.
  - Stimulus: program at 255 = MOVI R0,9; at 0 = OUT R0; at 1 = HALT; start_pc=255.
  - Required: out=0x0009.
- Restart from HALTED
  - Stimulus: start again without reset.
  - Required: pc reloads start_pc; out retained until the next OUT; halted drops the cycle after start.

Source files
------------

// File: rtl/srisc_core_mc.sv
// Multi-cycle 8-register CPU with a writable instruction memory, start/halted handshake and BNZ.
// Optional retired-instruction counter on port `retired` when SRISC_RETIRE_CNT_EN is defined.
module srisc_core_mc #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [15:0]       imem_wdata,
`ifdef SRISC_RETIRE_CNT_EN
    output logic [31:0]       retired,
`endif
    output logic [DATA_W-1:0] out,
    output logic              halted,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [2:0] OP_MOVI = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_MVN  = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_BNZ  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic [DATA_W-1:0]   regs_q [8];
    logic [15:0]         imem [DEPTH];
    logic                wb_en;
    logic [2:0]          wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                start_accept;
    logic                imem_wr_ok;
    logic [2:0]          op;

    assign op         = ir_q[15:13];
    assign imem_wr_ok = (state_q == S_IDLE) || (state_q == S_HALTED);

    // Instruction memory is never reset; writes are only honoured while the core is stopped.
    always_ff @(posedge clk) begin
        if (imem_we && imem_wr_ok) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= '0;
        end else if (state_q == S_FETCH) begin
            ir_q <= imem[pc_q];
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_d        = out_q;
        a_d          = a_q;
        b_d          = b_q;
        d_d          = d_q;
        wb_en        = 1'b0;
        wb_addr      = ir_q[12:10];
        wb_data      = '0;
        start_accept = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    start_accept = 1'b1;
                    pc_d         = start_pc;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = regs_q[ir_q[9:7]];
                b_d     = regs_q[ir_q[6:4]];
                d_d     = regs_q[ir_q[12:10]];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_MOVI: begin
                        wb_en        = 1'b1;
                        wb_data      = {DATA_W{ir_q[7]}};
                        wb_data[7:0] = ir_q[7:0];
                    end
                    OP_ADD: begin
                        wb_en   = 1'b1;
                        wb_data = a_q + b_q;
                    end
                    OP_SUB: begin
                        wb_en   = 1'b1;
                        wb_data = a_q - b_q;
                    end
                    OP_AND: begin
                        wb_en   = 1'b1;
                        wb_data = a_q & b_q;
                    end
                    OP_MVN: begin
                        wb_en   = 1'b1;
                        wb_data = ~b_q;
                    end
                    OP_OUT:  out_d = a_q;
                    OP_BNZ: begin
                        if (d_q != '0) begin
                            pc_d = ADDR_W'(ir_q[7:0]);
                        end
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: state_d = S_FETCH;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign out    = out_q;
    assign halted = (state_q == S_HALTED);
    assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);

`ifdef SRISC_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Counts EXEC cycles since the last accepted start, sticking at all-ones.
    always_comb begin
        retired_d = retired_q;
        if (start_accept) begin
            retired_d = '0;
        end else if (state_q == S_EXEC && retired_q != '1) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;
`endif
endmodule

// File: tb/tb_srisc_core_mc.sv
// Randomized self-checking bench: 16-bit and 8-bit cores run the same programs against an instruction-level model.
module tb_srisc_core_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_pc = '0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [15:0] out16;
    logic [7:0]  out8;
    logic        halted16, halted8, busy16, busy8;
`ifdef SRISC_RETIRE_CNT_EN
    logic [31:0] retired16, retired8;
`endif

    always #5 clk = ~clk;

    srisc_core_mc #(.DATA_W(16), .ADDR_W(8)) u_dut16 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
`ifdef SRISC_RETIRE_CNT_EN
        .retired    (retired16),
`endif
        .out        (out16),
        .halted     (halted16),
        .busy       (busy16)
    );

    srisc_core_mc #(.DATA_W(8), .ADDR_W(8)) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_pc   (start_pc),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
`ifdef SRISC_RETIRE_CNT_EN
        .retired    (retired8),
`endif
        .out        (out8),
        .halted     (halted8),
        .busy       (busy8)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 is the 16-bit core, index 1 the 8-bit core.
    logic [15:0] mimem [256];
    logic [31:0] mreg [2][8];
    logic [31:0] mout [2];
    int          exp_n [2];
    int          hcyc [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int rd, input int rn, input int rm);
        enc_r = {op[2:0], rd[2:0], rn[2:0], rm[2:0], 4'b0000};
    endfunction

    function automatic logic [15:0] enc_i(input int op, input int rd, input int imm);
        enc_i = {op[2:0], rd[2:0], 2'b00, imm[7:0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mout[k] = '0;
            for (int r = 0; r < 8; r++) mreg[k][r] = '0;
        end
    endtask

    // Instruction-level interpreter; returns the number of instructions executed including HALT.
    task automatic model_run(input int k, input int w, input logic [7:0] spc, output int n);
        logic [31:0] mask, a, b, d;
        logic [15:0] ir;
        logic [7:0]  pc;
        bit          done;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        pc = spc;
        n = 0;
        done = 0;
        while (!done && n < 400) begin
            ir = mimem[pc];
            pc = pc + 8'd1;
            n++;
            a = mreg[k][ir[9:7]];
            b = mreg[k][ir[6:4]];
            d = mreg[k][ir[12:10]];
            case (ir[15:13])
                3'd0: mreg[k][ir[12:10]] = {{24{ir[7]}}, ir[7:0]} & mask;
                3'd1: mreg[k][ir[12:10]] = (a + b) & mask;
                3'd2: mreg[k][ir[12:10]] = (a - b) & mask;
                3'd3: mreg[k][ir[12:10]] = a & b;
                3'd4: mreg[k][ir[12:10]] = ~b & mask;
                3'd5: mout[k] = a;
                3'd6: if (d != 0) pc = ir[7:0];
                default: done = 1;
            endcase
        end
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk);
        imem_we = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        mimem[addr] = data;
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    // Starts both cores at spc; with spurious=1 random imem writes are driven while both are busy.
    task automatic run_prog(input string name, input logic [7:0] spc, input bit spurious);
        int nmin, nmax, bound;
        logic [15:0] rnd;
        model_run(0, 16, spc, exp_n[0]);
        model_run(1, 8, spc, exp_n[1]);
        nmin = (exp_n[0] < exp_n[1]) ? exp_n[0] : exp_n[1];
        nmax = (exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1];
        bound = 3 * nmax + 10;
        hcyc[0] = -1;
        hcyc[1] = -1;
        @(negedge clk);
        start = 1'b1;
        start_pc = spc;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                check_eq({name, ".busy16_c1"}, 32'(busy16), 32'd1);
                check_eq({name, ".halted16_c1"}, 32'(halted16), 32'd0);
                check_eq({name, ".halted8_c1"}, 32'(halted8), 32'd0);
            end
            if (halted16 && hcyc[0] < 0) hcyc[0] = c;
            if (halted8 && hcyc[1] < 0) hcyc[1] = c;
            imem_we = 1'b0;
            if (spurious && c <= 3 * nmin && $urandom_range(0, 2) == 0) begin
                rnd = 16'($urandom());
                imem_we = 1'b1;
                imem_waddr = ($urandom_range(0, 1) == 0) ? 8'(spc + 8'($urandom_range(0, 7)))
                                                         : 8'($urandom());
                imem_wdata = rnd;
            end
            if (hcyc[0] >= 0 && hcyc[1] >= 0) break;
        end
        imem_we = 1'b0;
        check_eq({name, ".cycles16"}, 32'(hcyc[0]), 32'(3 * exp_n[0] + 1));
        check_eq({name, ".cycles8"}, 32'(hcyc[1]), 32'(3 * exp_n[1] + 1));
        check_eq({name, ".out16"}, 32'(out16), mout[0]);
        check_eq({name, ".out8"}, 32'(out8), mout[1]);
`ifdef SRISC_RETIRE_CNT_EN
        check_eq({name, ".retired16"}, retired16, 32'(exp_n[0]));
        check_eq({name, ".retired8"}, retired8, 32'(exp_n[1]));
`endif
    endtask

    task automatic load_sum_loop();
        load_word(8'd4,  enc_i(0, 0, 4));
        load_word(8'd5,  enc_i(0, 1, 8'hFF));
        load_word(8'd6,  enc_i(0, 2, 0));
        load_word(8'd7,  enc_r(1, 2, 2, 0));
        load_word(8'd8,  enc_r(1, 0, 0, 1));
        load_word(8'd9,  enc_i(6, 0, 7));
        load_word(8'd10, enc_r(5, 0, 2, 0));
        load_word(8'd11, enc_r(7, 0, 0, 0));
    endtask

    initial begin
        int len, base, op;
        logic [15:0] w;
        string tag;

        for (int i = 0; i < 256; i++) mimem[i] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("reset.out16", 32'(out16), 32'd0);
        check_eq("reset.out8", 32'(out8), 32'd0);
        check_eq("reset.busy16", 32'(busy16), 32'd0);
        check_eq("reset.halted16", 32'(halted16), 32'd0);
        check_eq("reset.busy8", 32'(busy8), 32'd0);
        check_eq("reset.halted8", 32'(halted8), 32'd0);

        // Sum loop: 4+3+2+1, seventeen instructions.
        load_sum_loop();
        run_prog("sum", 8'd4, 1'b0);
        check_eq("sum.halt_at_52", 32'(hcyc[0]), 32'd52);
        check_eq("sum.out_0x000a", 32'(out16), 32'h000A);
`ifdef SRISC_RETIRE_CNT_EN
        check_eq("sum.retired_17", retired16, 32'd17);
`endif

        // Reset in the middle of the loop aborts everything but the instruction memory.
        @(negedge clk);
        start = 1'b1;
        start_pc = 8'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_eq("midrst.out16", 32'(out16), 32'd0);
        check_eq("midrst.busy16", 32'(busy16), 32'd0);
        check_eq("midrst.halted16", 32'(halted16), 32'd0);
        check_eq("midrst.out8", 32'(out8), 32'd0);
        run_prog("sum_after_rst", 8'd4, 1'b0);
        check_eq("sum_after_rst.out_0x000a", 32'(out16), 32'h000A);

        // Width wrap on the 8-bit core.
        load_word(8'd20, enc_i(0, 0, 8'h7F));
        load_word(8'd21, enc_i(0, 1, 1));
        load_word(8'd22, enc_r(1, 2, 0, 1));
        load_word(8'd23, enc_r(5, 0, 2, 0));
        load_word(8'd24, enc_r(7, 0, 0, 0));
        run_prog("wrap_add", 8'd20, 1'b0);
        check_eq("wrap_add.out8_0x80", 32'(out8), 32'h80);
        check_eq("wrap_add.out16_0x0080", 32'(out16), 32'h0080);

        load_word(8'd30, enc_i(0, 4, 0));
        load_word(8'd31, enc_i(0, 5, 1));
        load_word(8'd32, enc_r(2, 6, 4, 5));
        load_word(8'd33, enc_r(5, 0, 6, 0));
        load_word(8'd34, enc_r(7, 0, 0, 0));
        run_prog("wrap_sub", 8'd30, 1'b0);
        check_eq("wrap_sub.out8_0xff", 32'(out8), 32'hFF);
        check_eq("wrap_sub.out16_0xffff", 32'(out16), 32'hFFFF);

        // Sign extension then MVN.
        load_word(8'd40, enc_i(0, 3, 8'h80));
        load_word(8'd41, enc_r(5, 0, 3, 0));
        load_word(8'd42, enc_r(7, 0, 0, 0));
        run_prog("sext", 8'd40, 1'b0);
        check_eq("sext.out16_0xff80", 32'(out16), 32'hFF80);
        load_word(8'd44, enc_r(4, 4, 0, 3));
        load_word(8'd45, enc_r(5, 0, 4, 0));
        load_word(8'd46, enc_r(7, 0, 0, 0));
        run_prog("mvn", 8'd44, 1'b0);
        check_eq("mvn.out16_0x007f", 32'(out16), 32'h007F);

        // Restart from HALTED with no OUT: out must be retained.
        load_word(8'd50, enc_i(0, 7, 5));
        load_word(8'd51, enc_r(7, 0, 0, 0));
        run_prog("restart", 8'd50, 1'b0);
        check_eq("restart.out16_kept", 32'(out16), 32'h007F);

        // Writes while busy must not land; rerun of the same program reads the original words.
        run_prog("busy_wr", 8'd50, 1'b1);
        run_prog("busy_wr_readback", 8'd50, 1'b0);
        check_eq("busy_wr_readback.out16_kept", 32'(out16), 32'h007F);

        // pc wrap from 255 to 0.
        load_word(8'd255, enc_i(0, 0, 9));
        load_word(8'd0, enc_r(5, 0, 0, 0));
        load_word(8'd1, enc_r(7, 0, 0, 0));
        run_prog("pcwrap", 8'd255, 1'b0);
        check_eq("pcwrap.out16_0x0009", 32'(out16), 32'h0009);

        // Random straight-line programs with forward branches and spurious writes.
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(3, 12);
            base = $urandom_range(60, 200);
            for (int i = 0; i < len - 1; i++) begin
                op = $urandom_range(0, 6);
                w = 16'($urandom());
                if (op == 6) begin
                    w = enc_i(6, $urandom_range(0, 7), $urandom_range(base + i + 1, base + len - 1));
                end else begin
                    w[15:13] = 3'(op);
                end
                load_word(8'(base + i), w);
            end
            load_word(8'(base + len - 1), enc_r(7, 0, 0, 0));
            tag = $sformatf("rand%0d", t);
            run_prog(tag, 8'(base), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
